// File: rtl/pe_issue_ctrl_if.sv
// Issue-controller bus: start/done handshake, instruction memory, data memory and ALU ports.
// master = the issue controller, slave = the surrounding PE (memories, ALU, CGRA top control).
interface pe_issue_ctrl_if #(
    parameter int DWIDTH = 32,
    parameter int DAW    = 8,
    parameter int IAW    = 10,
    parameter int INST_W = 4 + 4 * DAW + 1
);
    logic              Start;
    logic [IAW:0]      Inst_Count;
    logic              Busy;
    logic              Done;
    logic              Inst_Rd_En;
    logic [IAW-1:0]    Inst_Addr;
    logic [INST_W-1:0] Inst_Data;
    logic              Rd_En;
    logic [DAW-1:0]    Rd_Addr0, Rd_Addr1, Rd_Addr2;
    logic [DWIDTH-1:0] Rd_Data0, Rd_Data1, Rd_Data2;
    logic [3:0]        OP_Sel;
    logic [DWIDTH-1:0] Alu_In0, Alu_In1, Alu_In2;
    logic [DWIDTH-1:0] Alu_Out;
    logic              Wr_En;
    logic [DAW-1:0]    Wr_Addr;
    logic [DWIDTH-1:0] Wr_Data;

    modport master (
        input  Start, Inst_Count, Inst_Data, Rd_Data0, Rd_Data1, Rd_Data2, Alu_Out,
        output Busy, Done, Inst_Rd_En, Inst_Addr, Rd_En, Rd_Addr0, Rd_Addr1, Rd_Addr2,
               OP_Sel, Alu_In0, Alu_In1, Alu_In2, Wr_En, Wr_Addr, Wr_Data
    );

    modport slave (
        output Start, Inst_Count, Inst_Data, Rd_Data0, Rd_Data1, Rd_Data2, Alu_Out,
        input  Busy, Done, Inst_Rd_En, Inst_Addr, Rd_En, Rd_Addr0, Rd_Addr1, Rd_Addr2,
               OP_Sel, Alu_In0, Alu_In1, Alu_In2, Wr_En, Wr_Addr, Wr_Data
    );
endinterface

// File: rtl/pe_issue_ctrl.sv
// Static-schedule issue/writeback controller for one CGRA PE.
// One instruction issued per RUN cycle; operands fetched the next cycle, presented to the
// ALU the cycle after, and the result written back a fixed ALU_LAT cycles later.
// vld_pipe bit map: [0] operand read, [1] ALU input, [2..STAGES-1] ALU latency,
// [STAGES-1] result sample point, [STAGES] writeback.
module pe_issue_ctrl #(
    parameter int DWIDTH  = 32,
    parameter int DAW     = 8,
    parameter int IAW     = 10,
    parameter int ALU_LAT = 8
) (
    input  logic           Clk,
    input  logic           Resetn,
    pe_issue_ctrl_if.master bus
);
    localparam int STAGES = ALU_LAT + 2;
    localparam logic [IAW-1:0] PC_INC  = 1;
    localparam logic [IAW:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Field order mirrors the instruction word, MSB first.
    typedef struct packed {
        logic           we;
        logic [DAW-1:0] dst;
        logic [DAW-1:0] src2;
        logic [DAW-1:0] src1;
        logic [DAW-1:0] src0;
        logic [3:0]     op;
    } inst_t;

    state_e                      state_q, state_d;
    logic [IAW-1:0]              pc_q, pc_d;
    logic [IAW:0]                cnt_q, cnt_d;
    logic [STAGES:0]             vld_pipe_q, vld_pipe_d;
    logic [3:0]                  op_q, op_d;
    logic [ALU_LAT:0][DAW-1:0]   dst_pipe_q, dst_pipe_d;
    logic [ALU_LAT:0]            we_pipe_q, we_pipe_d;
    logic                        wb_we_q, wb_we_d;
    logic [DAW-1:0]              wb_addr_q, wb_addr_d;
    logic [DWIDTH-1:0]           wb_data_q, wb_data_d;

    inst_t inst;
    logic  issue;
    logic  last_issue;
    logic  pipe_empty;

    assign inst       = inst_t'(bus.Inst_Data);
    assign issue      = (state_q == RUN);
    assign last_issue = issue && ({1'b0, pc_q} == cnt_q - CNT_ONE);
    // The writeback stage is excluded: a write in flight now completes at this edge,
    // so Done can follow in the very next cycle.
    assign pipe_empty = ~|vld_pipe_q[STAGES-1:0];

    // State and datapath registers; reset aborts any run and drops pending writes.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            op_q       <= '0;
            dst_pipe_q <= '0;
            we_pipe_q  <= '0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            op_q       <= op_d;
            dst_pipe_q <= dst_pipe_d;
            we_pipe_q  <= we_pipe_d;
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Next-state: Start only honoured in IDLE; an empty run goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start) state_d = (bus.Inst_Count == '0) ? DONE : RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.Busy       = 1'b0;
        bus.Done       = 1'b0;
        bus.Inst_Rd_En = 1'b0;
        case (state_q)
            RUN: begin
                bus.Busy       = 1'b1;
                bus.Inst_Rd_En = 1'b1;
            end
            DRAIN:   bus.Busy = 1'b1;
            DONE:    bus.Done = 1'b1;
            default: ;
        endcase
    end

    // PC/count and the fixed-latency pipeline; no stalls, so everything shifts every cycle.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (state_q == IDLE && bus.Start) begin
            pc_d  = '0;
            cnt_d = bus.Inst_Count;
        end else if (issue) begin
            pc_d = pc_q + PC_INC;
        end

        vld_pipe_d = {vld_pipe_q[STAGES-1:0], issue};
        op_d       = inst.op;
        dst_pipe_d = {dst_pipe_q[ALU_LAT-1:0], inst.dst};
        we_pipe_d  = {we_pipe_q[ALU_LAT-1:0], inst.we};

        // Result sampled only for valid slots; address/data hold otherwise.
        wb_we_d   = we_pipe_q[ALU_LAT];
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (vld_pipe_q[STAGES-1]) begin
            wb_addr_d = dst_pipe_q[ALU_LAT];
            wb_data_d = bus.Alu_Out;
        end
    end

    // Operand read addresses come straight from the fetched word; gated so idle slots read 0.
    always_comb begin
        bus.Inst_Addr = pc_q;
        bus.Rd_En     = vld_pipe_q[0];
        bus.Rd_Addr0  = vld_pipe_q[0] ? inst.src0 : '0;
        bus.Rd_Addr1  = vld_pipe_q[0] ? inst.src1 : '0;
        bus.Rd_Addr2  = vld_pipe_q[0] ? inst.src2 : '0;
        bus.OP_Sel    = vld_pipe_q[1] ? op_q : '0;
        bus.Alu_In0   = vld_pipe_q[1] ? bus.Rd_Data0 : '0;
        bus.Alu_In1   = vld_pipe_q[1] ? bus.Rd_Data1 : '0;
        bus.Alu_In2   = vld_pipe_q[1] ? bus.Rd_Data2 : '0;
        bus.Wr_En     = vld_pipe_q[STAGES] & wb_we_q;
        bus.Wr_Addr   = wb_addr_q;
        bus.Wr_Data   = wb_data_q;
    end
endmodule
